// File: rtl/operand_shift_tx_if.sv
// Handshake and serial-output bundle between an operand source and operand_shift_tx.
interface operand_shift_tx_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ready;
  logic             ser_a;
  logic             ser_b;
  logic             latch;
  logic             busy;
  logic [7:0]       words_sent;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, ser_a, ser_b, latch, busy, words_sent
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, ser_a, ser_b, latch, busy, words_sent
  );
endinterface

// File: rtl/operand_shift_tx.sv
// Serialises operand pairs MSB-first onto two lines, then pulses a latch strobe
// so a shift-in multiplier front-end captures the whole word.
module operand_shift_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_shift_tx_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    GAPW
  } state_t;

  state_t             state_q;
  logic               full_q;
  logic [WIDTH-1:0]   buf_a_q;
  logic [WIDTH-1:0]   buf_b_q;
  logic [WIDTH-2:0]   sh_a_q;
  logic [WIDTH-2:0]   sh_b_q;
  logic [CW-1:0]      bit_q;
  logic [3:0]         gap_q;
  logic               ser_a_q;
  logic               ser_b_q;
  logic               latch_q;
  logic [7:0]         words_q;

  logic               accept;
  logic               load;
  logic               engine_free;

  // Buffer can only be accepted into while empty, and only loaded while full,
  // so the two never happen on the same edge.
  assign accept = bus.in_valid && !full_q;

  always_comb begin
    engine_free = 1'b0;
    unique case (state_q)
      IDLE:    engine_free = 1'b1;
      SHIFT:   engine_free = 1'b0;
      LATCH:   engine_free = (GAP == 0);
      GAPW:    engine_free = (gap_q == '0);
      default: engine_free = 1'b0;
    endcase
  end

  assign load = full_q && engine_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else if (accept) begin
      full_q  <= 1'b1;
      buf_a_q <= bus.in_a;
      buf_b_q <= bus.in_b;
    end else if (load) begin
      full_q  <= 1'b0;
    end
  end

  // The MSB leaves on the load edge itself, so the shift register only keeps
  // the remaining WIDTH-1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      ser_a_q <= 1'b0;
      ser_b_q <= 1'b0;
      latch_q <= 1'b0;
      words_q <= '0;
    end else begin
      ser_a_q <= 1'b0;
      ser_b_q <= 1'b0;
      latch_q <= 1'b0;
      if (load) begin
        state_q <= SHIFT;
        sh_a_q  <= buf_a_q[WIDTH-2:0];
        sh_b_q  <= buf_b_q[WIDTH-2:0];
        ser_a_q <= buf_a_q[WIDTH-1];
        ser_b_q <= buf_b_q[WIDTH-1];
        bit_q   <= CW'(WIDTH - 1);
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          SHIFT: begin
            if (bit_q == '0) begin
              state_q <= LATCH;
              latch_q <= 1'b1;
              words_q <= words_q + 8'd1;
            end else begin
              ser_a_q <= sh_a_q[WIDTH-2];
              ser_b_q <= sh_b_q[WIDTH-2];
              sh_a_q  <= sh_a_q << 1;
              sh_b_q  <= sh_b_q << 1;
              bit_q   <= bit_q - 1'b1;
            end
          end
          LATCH: begin
            if (GAP != 0) begin
              state_q <= GAPW;
              gap_q   <= 4'(GAP - 1);
            end else begin
              state_q <= IDLE;
            end
          end
          GAPW: begin
            if (gap_q != '0) begin
              gap_q <= gap_q - 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = !full_q;
  assign bus.ser_a      = ser_a_q;
  assign bus.ser_b      = ser_b_q;
  assign bus.latch      = latch_q;
  assign bus.busy       = (state_q != IDLE) || full_q;
  assign bus.words_sent = words_q;

endmodule

// File: doc/operand_shift_tx.md
OPERAND_SHIFT_TX -- requirements
Module: operand_shift_tx

Purpose: drives two serial operand streams plus a latch strobe into a multiplier front-end. That front-end shifts its LSB in on each posedge and latches the full word while the strobe is high.

Interface
REQ-001 Parameter WIDTH, default 16, serial word length in bits (2..32).
REQ-002 Parameter GAP, default 0, idle cycles inserted after each latch strobe (0..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_a  input  WIDTH  operand A.
REQ-007 in_b  input  WIDTH  operand B.
REQ-008 in_ready  output  1  holding buffer empty; transfer occurs on the posedge where in_valid and in_ready are both 1.
REQ-009 ser_a  output  1  serial stream A, registered.
REQ-010 ser_b  output  1  serial stream B, registered.
REQ-011 latch  output  1  latch strobe, registered, one cycle per word.
REQ-012 busy  output  1  high whenever the state is not IDLE or the buffer is full.
REQ-013 words_sent  output  8  count of latch strobes issued, wrapping 255->0.

Function
REQ-014 The block SHALL contain a one-entry holding buffer (A, B, full flag); in_ready SHALL equal NOT full, with no combinational path from in_valid.
REQ-015 An accepted pair SHALL set full on the accepting edge, with data captured unchanged.
REQ-016 The engine SHALL have states IDLE, SHIFT, LATCH and GAPW.
REQ-017 IDLE->SHIFT on any edge where full=1. This edge loads the shift registers from the buffer, clears full, sets bit counter = WIDTH-1, and drives ser_a/ser_b = MSB of A/B.
REQ-018 In SHIFT, each edge SHALL advance one bit toward the LSB. The MSB appears in the first SHIFT cycle and the LSB in cycle WIDTH, so the receiver holds the word MSB-aligned after WIDTH samples.
REQ-019 After the LSB cycle, the next edge SHALL enter LATCH: latch=1 for exactly one cycle, ser_a=ser_b=0, and words_sent increments on that edge.
REQ-020 LATCH exit: if GAP>0, enter GAPW for GAP cycles (ser=0, latch=0), then proceed as below.
REQ-021 LATCH exit with GAP=0 (or GAPW end): go to SHIFT loading the buffer if full=1, else go to IDLE.
REQ-022 Back-to-back throughput SHALL be one word per WIDTH+1+GAP cycles; the first-bit latency from the accept edge SHALL be one edge (accept edge e, MSB driven after edge e+1).
REQ-023 A buffer-load edge and a new accept SHALL NOT coincide, because in_ready=0 while full=1. A new accept is possible from the cycle after the load edge.
REQ-024 In IDLE, ser_a=ser_b=latch=0.
REQ-025 in_valid/in_a/in_b changes while in_ready=0 SHALL have no effect.
REQ-026 Operand values SHALL be transmitted unmodified; no arithmetic is performed on them.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, full=0, and shift registers, counters and words_sent to 0. It also forces ser_a=ser_b=latch=0, in_ready=1 and busy=0.
REQ-028 Reset mid-word SHALL discard the in-flight word and the buffered word without issuing latch.
REQ-029 After rst_n deasserts, the first accept SHALL be possible on the first posedge.

Verification
REQ-030 Single word, WIDTH=16, GAP=0: A=0xA5C3, B=0x1234 accepted at edge 0 -> ser_a = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 in cycles 1..16; latch=1 in cycle 17 only; words_sent=1.
REQ-031 Back-to-back: two pairs offered continuously -> the second MSB is driven in the cycle after the latch cycle; 17 cycles per word; no bubble.
REQ-032 GAP=3: two queued words -> 3 cycles with ser=0 and latch=0 between the latch strobe and the second MSB.
REQ-033 Backpressure: in_valid held high while the buffer is full and the engine is in SHIFT -> in_ready=0; data changes are ignored; the pair is accepted on the edge after the buffer loads.
REQ-034 Reset at SHIFT cycle 8 -> outputs are 0 immediately; no latch is issued; the next word transmits correctly.
REQ-035 Wrap: 256 words -> words_sent returns to 0; a receiver model reassembles every A/B pair exactly.
